// File: rtl/ct_l2c_data_arb_ctrl_pkg.sv
// ct_l2c_data_arb_ctrl_pkg: shared FSM encoding, line/beat sizes and read-latency range
package ct_l2c_data_arb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10} arb_state_t;
    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_W = 128;
    localparam int LINE_W = 512;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
endpackage

// File: rtl/ct_l2c_data_arb_ctrl_rd_lat_pipe.sv
// ct_l2c_data_rd_lat_pipe: RD_LAT-deep valid/beat shift that tags SRAM read data on return
module ct_l2c_data_rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [1:0] in_beat,
    output logic       out_vld,
    output logic [1:0] out_beat,
    output logic       any_vld
);
    logic [RD_LAT-1:0]      vld_q;
    logic [RD_LAT-1:0][1:0] beat_q;
    // shift the issued beat along with the SRAM latency; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            beat_q <= '0;
        end else begin
            vld_q[0]  <= in_vld;
            beat_q[0] <= in_beat;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                beat_q[i] <= beat_q[i-1];
            end
        end
    end
    assign out_vld  = vld_q[RD_LAT-1];
    assign out_beat = beat_q[RD_LAT-1];
    assign any_vld  = |vld_q;
endmodule

// File: rtl/ct_l2c_data_arb_ctrl.sv
// ct_l2c_data_arb_ctrl: read/write arbiter and 4-beat sequencer for one L2 data SRAM bank
// Option: define L2C_DATA_ARB_RR_EN for round-robin arbitration; default is write over read
module ct_l2c_data_arb_ctrl
    import ct_l2c_data_arb_ctrl_pkg::*;
#(
    parameter int DATA_INDEX_WIDTH = 13,
    parameter int RD_LAT = 1
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        rd_req_vld,
    input  logic [DATA_INDEX_WIDTH-3:0] rd_req_idx,
    output logic                        rd_req_gnt,
    input  logic                        wr_req_vld,
    input  logic [DATA_INDEX_WIDTH-3:0] wr_req_idx,
    input  logic [LINE_W-1:0]           wr_req_data,
    output logic                        wr_req_gnt,
    output logic                        rd_data_vld,
    output logic [BEAT_W-1:0]           rd_data,
    output logic [1:0]                  rd_data_beat,
    output logic                        rd_data_last,
    output logic                        ctrl_busy,
    output logic                        data_cen,
    output logic                        data_gwen,
    output logic [BEAT_W-1:0]           data_wen,
    output logic [DATA_INDEX_WIDTH-1:0] data_idx,
    output logic [BEAT_W-1:0]           data_din,
    input  logic [BEAT_W-1:0]           data_dout
);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);

    arb_state_t                  state, nxt_state;
    logic [1:0]                  beat, nxt_beat;
    logic [DATA_INDEX_WIDTH-3:0] line_q, nxt_line;
    logic [LINE_W-1:0]           wdata_q, nxt_wdata;
    logic                        idle, wr_win, lat_any;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("RD_LAT must be within 1..3");
    end

    assign idle = state == IDLE && cpurst_b;

`ifdef L2C_DATA_ARB_RR_EN
    logic last_wr;
    // remember the most recent winner; cleared so the first contention goes to write
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) last_wr <= 1'b0;
        else if (rd_req_gnt || wr_req_gnt) last_wr <= wr_req_gnt;
    end
    assign wr_win = wr_req_vld && (!rd_req_vld || !last_wr);
`else
    assign wr_win = wr_req_vld;
`endif

    // grant decode: only an idle bank accepts a request
    always_comb begin
        wr_req_gnt = idle && wr_win;
        rd_req_gnt = idle && rd_req_vld && !wr_win;
    end

    // state register, beat counter and request latches
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= IDLE;
            beat    <= 2'd0;
            line_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= nxt_state;
            beat    <= nxt_beat;
            line_q  <= nxt_line;
            wdata_q <= nxt_wdata;
        end
    end

    // next state: a grant opens a burst, the last beat closes it
    always_comb begin
        nxt_state = state;
        nxt_beat  = 2'd0;
        if (state == IDLE) nxt_state = wr_req_gnt ? WR : rd_req_gnt ? RD : IDLE;
        else begin
            nxt_beat  = beat + 2'd1;
            nxt_state = beat == LAST_BEAT ? IDLE : state;
        end
    end

    assign nxt_line  = rd_req_gnt ? rd_req_idx : wr_req_gnt ? wr_req_idx : line_q;
    assign nxt_wdata = wr_req_gnt ? wr_req_data : wdata_q;

    // SRAM controls registered from the next-cycle view so they line up with the burst state
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            data_cen  <= 1'b1;
            data_gwen <= 1'b1;
            data_wen  <= '1;
            data_idx  <= '0;
            data_din  <= '0;
        end else begin
            data_cen  <= nxt_state == IDLE;
            data_gwen <= nxt_state != WR;
            data_wen  <= {BEAT_W{nxt_state != WR}};
            if (nxt_state != IDLE) data_idx <= {nxt_line, nxt_beat};
            if (nxt_state == WR) data_din <= nxt_wdata[BEAT_W*nxt_beat +: BEAT_W];
        end
    end

    ct_l2c_data_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
        .clk      (forever_cpuclk),
        .rst_n    (cpurst_b),
        .in_vld   (state == RD),
        .in_beat  (beat),
        .out_vld  (rd_data_vld),
        .out_beat (rd_data_beat),
        .any_vld  (lat_any)
    );

    assign rd_data      = data_dout;
    assign rd_data_last = rd_data_vld && rd_data_beat == LAST_BEAT;
    assign ctrl_busy    = state != IDLE || lat_any;
endmodule

// File: doc/ct_l2c_data_arb_ctrl.md
Name: ct_l2c_data_arb_ctrl

Overview:
Sequencer and arbiter in front of one L2 cache data bank: the single-port 128-bit SRAM with active-low CEN/GWEN/WEN controls.
- Two requesters share the bank:
  - a read requester (tag pipeline hit/victim read);
  - a write requester (refill/store-merge).
- Each request is a full 64-byte line, serialised as 4 beats of 128 bits.
- Read beats return with fixed SRAM latency, tagged with beat number.

Parameters:
DATA_INDEX_WIDTH, 13, SRAM address width; low 2 bits select the beat, upper bits select the line.
RD_LAT, 1, cycles from SRAM access (CEN low) to data_dout valid; legal values 1..3.

Ports:
forever_cpuclk  in  1  block clock
cpurst_b  in  1  asynchronous active-low reset
rd_req_vld  in  1  read line request
rd_req_idx  in  DATA_INDEX_WIDTH-2  read line index
rd_req_gnt  out  1  read request accepted (1-cycle pulse)
wr_req_vld  in  1  write line request
wr_req_idx  in  DATA_INDEX_WIDTH-2  write line index
wr_req_data  in  512  line data; beat k = bits [128k+127:128k]
wr_req_gnt  out  1  write request accepted (1-cycle pulse)
rd_data_vld  out  1  returned beat valid
rd_data  out  128  returned beat data
rd_data_beat  out  2  beat number of rd_data
rd_data_last  out  1  beat 3 of line
ctrl_busy  out  1  burst in progress or read data outstanding
data_cen  out  1  SRAM chip enable, active low
data_gwen  out  1  SRAM global write enable, active low (0 = write)
data_wen  out  128  SRAM bit write enable, active low
data_idx  out  DATA_INDEX_WIDTH  SRAM address
data_din  out  128  SRAM write data
data_dout  in  128  SRAM read data

Behaviour:
Clock and reset (already decided): one clock, forever_cpuclk; reset cpurst_b is asynchronous, active-low.

Reset values:
- data_cen=1, data_gwen=1, data_wen=all 1s, data_idx=0, data_din=0.
- gnt, rd_data_vld, rd_data_last, ctrl_busy all 0.
- FSM=IDLE, beat counter=0, latency pipe cleared.

FSM states: IDLE, RD, WR.
- Arbitration happens only in IDLE. The gnt pulse is combinational in the IDLE cycle.
- The accepted request's index, and for writes its 512-bit data, are latched at grant.
- IDLE to RD on rd grant; IDLE to WR on wr grant.
- RD/WR: 4 consecutive cycles with beat counter 0..3. Return to IDLE after beat 3.
- The bank is therefore idle for one cycle between bursts; 5 cycles per line.

SRAM controls (registered, driven in RD/WR cycles):
- data_cen=0.
- data_idx={line_idx, beat}.
- RD: data_gwen=1.
- WR: data_gwen=0, data_wen=all 0s, data_din=latched beat.
- Outside bursts: data_cen=1, data_gwen=1, data_wen=all 1s. data_idx and data_din hold their last value.

Read return:
- A beat issued in cycle T gives rd_data_vld=1 in cycle T+RD_LAT.
- rd_data=data_dout, passed through with no register.
- rd_data_beat and rd_data_last come from a RD_LAT-deep shift of {vld, beat}.
- There is no back-pressure: the consumer must accept every beat.

Requester handshake:
- vld must be held with idx/data stable until gnt. Stability is not checked.
- Dropping vld before gnt is allowed; the request is simply lost.

Ordering:
- Bursts are never interleaved or pre-empted.
- A read accepted after a write to the same line returns the new data, because access is serialised.

ctrl_busy: 1 while the FSM is not IDLE or the latency pipe holds any valid beat.

Boundaries:
- Index wrap: all-ones line index and beat 3 give data_idx all ones. No carry.
- Simultaneous rd and wr vld in IDLE: resolved per the Optional Feature.
- Reset asserted mid-burst: controls return immediately (asynchronously) to reset values. The partial burst is abandoned and in-flight read beats are discarded with no rd_data_vld. The requester reissues.

Optional Feature:
Macro L2C_DATA_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-winner flag gives priority to the requester not granted most recently.
  - After reset the flag favours write.
- Undefined: fixed priority, write over read. Under continuous writes, reads can starve; this is acceptable because refill traffic is bounded upstream.

Decomposition:
- Shared package/header (cpu_cfig.h-style defines):
  - FSM state encodings (IDLE=2'b00, RD=2'b01, WR=2'b10);
  - BEATS_PER_LINE=4, BEAT_W=128, LINE_W=512;
  - RD_LAT legal range.
- Natural sub-module: ct_l2c_data_rd_lat_pipe, the RD_LAT-deep valid/beat shift register with asynchronous clear.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Single read, line 0x5, RD_LAT=1: gnt in cycle 0. data_cen=0 in cycles 1-4 with data_idx 0x14..0x17 and gwen=1. rd_data_vld in cycles 2-5 with beat 0..3, last=1 in cycle 5.
2. Single write, line 0x3, data beats 0xA..,0xB..,0xC..,0xD..: data_gwen=0 and data_wen=0 in cycles 1-4 with data_idx 0xC..0xF and din in order. A read of line 0x3 then returns the same 4 beats.
3. rd and wr vld together in IDLE, macro undefined: wr_req_gnt first. After the 4 write beats and 1 idle cycle, rd_req_gnt is asserted.
4. Same as scenario 3 with L2C_DATA_ARB_RR_EN: first winner is wr, next is rd, then wr alternating under continuous requests. No requester gets two consecutive grants while the other waits.
5. RD_LAT=3, back-to-back reads of lines 1 and 2: 8 beats returned in order with correct beat tags. ctrl_busy stays 1 until the last beat is returned.
6. cpurst_b asserted after beat 1 of a read: data_cen=1 immediately. No further rd_data_vld. FSM is IDLE after release, and a new request is granted normally.
